ofm_pack_buffer: RTL and testbench
==================================

# ofm_pack_buffer

Collects the compute engine's 8-bit OFM pixel stream and packs it into AXI_DATA_W-wide words in a BURST_LEN-deep tile buffer. When a tile is complete it hands the buffer to the downstream AXI OFM write master through a start/done handshake. During the write burst it serves that master's synchronous read port, supplying data and byte strobes. Single tile buffer, no ping-pong: pixel input stalls while a tile drains.

## Interface
- AXI_ADDR_W, 32, DDR address width
- AXI_DATA_W, 128, packed word width; BPW = AXI_DATA_W/8 pixels per word (16)
- BUF_ADDR_W, 10, read-port address width; must satisfy 2^BUF_ADDR_W >= BURST_LEN
- BURST_LEN, 128, words per tile, equal to the write master's burst length
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- pix_in  in  8  pixel byte
- pix_valid  in  1  pixel present
- pix_ready  out  1  block accepts a pixel this cycle
- pix_last  in  1  final pixel of tile, qualified by pix_valid && pix_ready
- cfg_base  in  AXI_ADDR_W  DDR start address for the next tile
- cfg_load  in  1  load cfg_base into the next-tile pointer
- start_write  out  1  level request to the write master (the master edge-detects it)
- base_addr  out  AXI_ADDR_W  DDR address of the buffered tile; stable while start_write=1
- wr_done  in  1  1-cycle completion pulse from the write master
- rd_addr  in  BUF_ADDR_W  buffer read address
- axi_out_data  out  AXI_DATA_W  read data
- axi_wstrb  out  AXI_DATA_W/8  read strobe, one bit per byte lane
- tile_cnt  out  16  tiles completed, incremented on each accepted wr_done

## Operation
- States: FILL, PAD, WAIT.
- Reset enters FILL; word_idx=0, lane=0, next_addr=0.
- FILL: pix_ready=1. An accepted pixel goes to byte lane `lane` (bits 8*lane+7:8*lane, little-endian) of the assembly register, and its strobe bit is set.
- Word commit happens on the accepting edge itself, with the incoming byte merged, when either lane==BPW-1 or pix_last=1. The commit writes the word and its strobe to buffer[word_idx], clears the assembly register and its strobes, sets lane=0 and increments word_idx.
- Unused lanes of a partial word hold data 0 and strobe 0.
- Tile end is either pix_last or commit of word BURST_LEN-1, whichever comes first.
  - If word_idx after commit is less than BURST_LEN, go to PAD.
  - Otherwise go to WAIT.
  - On that edge, base_addr <= next_addr.
- PAD: pix_ready=0. Write data 0 and strobe 0 to buffer[word_idx], one word per cycle, incrementing word_idx. After writing word BURST_LEN-1, go to WAIT. This guarantees that every beat of the fixed-length burst carries a defined strobe.
- WAIT: pix_ready=0, start_write=1. On wr_done:
  - start_write falls and the state returns to FILL.
  - word_idx=0, tile_cnt+1.
  - next_addr <= next_addr + BURST_LEN*AXI_DATA_W/8, modulo 2^AXI_ADDR_W.
- wr_done outside WAIT is ignored.
- cfg_load, in any state: next_addr <= cfg_base. It takes priority over the WAIT increment in the same cycle. It never changes base_addr during WAIT.
- Read port operates in any state: axi_out_data/axi_wstrb <= buffer[rd_addr] on each edge. rd_addr >= BURST_LEN returns undefined data.

## Timing
- Reset values: pix_ready=0, start_write=0, base_addr=0, axi_out_data=0, axi_wstrb=0, tile_cnt=0. pix_ready rises on the first edge after reset release.
- pix_ready, start_write and base_addr are registered outputs.
- Read latency is 1 cycle, from rd_addr to axi_out_data/axi_wstrb.
- Fill throughput: 1 pixel/clk; a full tile takes BURST_LEN*BPW accepted cycles.
- After the commit edge of the tile's final word, start_write=1 on the next cycle, or after (BURST_LEN - word_idx) PAD cycles for a partial tile.
- On the edge where wr_done is sampled, start_write goes low and pix_ready goes high on the same edge.
- Reset mid-operation discards the tile: buffer contents are don't-care, the state is FILL, and start_write drops immediately (asynchronously).
- tile_cnt wraps 0xFFFF -> 0.

## Test plan
- Full tile: cfg_base=0x1000_0000, pixels 0,1,2,... (mod 256), 2048 bytes, no pix_last -> start_write high 1 cycle after byte 2047, base_addr=0x1000_0000, rd_addr=0 gives 0x0F0E..0100 with strobe 0xFFFF, rd_addr=127 gives strobe 0xFFFF.
- Partial tile: 20 bytes, last with pix_last -> word1 strobe 0x000F, words 2..127 data 0 and strobe 0, 126 PAD cycles, then start_write.
- pix_last on the first byte -> word0 strobe 0x0001, 127 PAD cycles.
- Handoff and stall: hold pix_valid=1 through WAIT -> pix_ready=0 and no commits. wr_done pulse -> start_write low, tile_cnt=1, second tile base_addr=0x1000_0800. Spurious wr_done during FILL has no effect.
- Address update and wrap:
  - cfg_base=0xFFFF_F800 -> the tile after it has base_addr 0x0000_0000.
  - cfg_load=0x2000_0000 in the same cycle as wr_done -> next base_addr=0x2000_0000.
- Reset asserted mid-PAD -> all outputs at reset values; a new 16-byte tile then reads back strobe 0xFFFF in word0.

Source files
------------

// File: rtl/ofm_pack_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ofm_pack_buffer                                                          |
// | Packs 8-bit OFM pixels into wide words in a single tile buffer and hands |
// | the full tile to the AXI write master through start_write / wr_done.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module ofm_pack_buffer #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 128,
  parameter int BUF_ADDR_W = 10,
  parameter int BURST_LEN  = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              pix_in,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  input  logic                    pix_last,
  input  logic [AXI_ADDR_W-1:0]   cfg_base,
  input  logic                    cfg_load,
  output logic                    start_write,
  output logic [AXI_ADDR_W-1:0]   base_addr,
  input  logic                    wr_done,
  input  logic [BUF_ADDR_W-1:0]   rd_addr,
  output logic [AXI_DATA_W-1:0]   axi_out_data,
  output logic [AXI_DATA_W/8-1:0] axi_wstrb,
  output logic [15:0]             tile_cnt
);

  localparam int c_BPW    = AXI_DATA_W / 8;
  localparam int c_LANE_W = $clog2(c_BPW);
  localparam int c_PTR_W  = $clog2(BURST_LEN);
  localparam int c_IDX_W  = c_PTR_W + 1;
  localparam int c_RD_W   = BUF_ADDR_W + 1;

  localparam logic [c_LANE_W-1:0]   c_LAST_LANE  = c_LANE_W'(c_BPW - 1);
  localparam logic [c_IDX_W-1:0]    c_LAST_IDX   = c_IDX_W'(BURST_LEN - 1);
  localparam logic [c_RD_W-1:0]     c_BURST_EXT  = c_RD_W'(BURST_LEN);
  localparam logic [AXI_ADDR_W-1:0] c_TILE_BYTES = AXI_ADDR_W'(BURST_LEN * c_BPW);

  localparam logic [1:0] c_ST_FILL = 2'd0;
  localparam logic [1:0] c_ST_PAD  = 2'd1;
  localparam logic [1:0] c_ST_WAIT = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic [c_IDX_W-1:0]    r_word_idx;
  logic [c_LANE_W-1:0]   r_lane;
  logic [AXI_DATA_W-1:0] r_asm_data;
  logic [c_BPW-1:0]      r_asm_strb;
  logic [AXI_ADDR_W-1:0] r_next_addr;

  logic [AXI_DATA_W-1:0] r_mem_data [BURST_LEN];
  logic [c_BPW-1:0]      r_mem_strb [BURST_LEN];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_tile_end;
  logic                  w_done_ok;
  logic                  w_mem_we;
  logic [AXI_DATA_W-1:0] w_word_data;
  logic [c_BPW-1:0]      w_word_strb;
  logic                  w_rd_hit;

  assign w_accept    = pix_valid & pix_ready;
  assign w_word_data = r_asm_data | (AXI_DATA_W'(pix_in) << {r_lane, 3'b000});
  assign w_word_strb = r_asm_strb | (c_BPW'(1) << r_lane);
  assign w_commit    = w_accept & (pix_last | (r_lane == c_LAST_LANE));
  // The tile also ends when the last buffer word fills without pix_last.
  assign w_tile_end  = w_accept & (pix_last |
                       ((r_lane == c_LAST_LANE) & (r_word_idx == c_LAST_IDX)));
  assign w_done_ok   = (r_state == c_ST_WAIT) & wr_done;
  assign w_mem_we    = w_commit | (r_state == c_ST_PAD);
  assign w_rd_hit    = ({1'b0, rd_addr} < c_BURST_EXT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_FILL: if (w_tile_end)
                   w_state_nxt = (r_word_idx == c_LAST_IDX) ? c_ST_WAIT : c_ST_PAD;
      c_ST_PAD:  if (r_word_idx == c_LAST_IDX) w_state_nxt = c_ST_WAIT;
      c_ST_WAIT: if (wr_done) w_state_nxt = c_ST_FILL;
      default:   w_state_nxt = c_ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_ST_FILL;
      pix_ready    <= 1'b0;
      start_write  <= 1'b0;
      r_word_idx   <= '0;
      r_lane       <= '0;
      r_asm_data   <= '0;
      r_asm_strb   <= '0;
      r_next_addr  <= '0;
      base_addr    <= '0;
      tile_cnt     <= '0;
      axi_out_data <= '0;
      axi_wstrb    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      pix_ready   <= (w_state_nxt == c_ST_FILL);
      start_write <= (w_state_nxt == c_ST_WAIT);

      if (w_mem_we)
        r_word_idx <= r_word_idx + c_IDX_W'(1);
      else if (w_done_ok)
        r_word_idx <= '0;

      if (w_commit) begin
        r_lane     <= '0;
        r_asm_data <= '0;
        r_asm_strb <= '0;
      end else if (w_accept) begin
        r_lane     <= r_lane + c_LANE_W'(1);
        r_asm_data <= w_word_data;
        r_asm_strb <= w_word_strb;
      end

      if (w_tile_end)
        base_addr <= r_next_addr;

      if (cfg_load)
        r_next_addr <= cfg_base;
      else if (w_done_ok)
        r_next_addr <= r_next_addr + c_TILE_BYTES;

      if (w_done_ok)
        tile_cnt <= tile_cnt + 16'd1;

      // Out-of-range reads return zero rather than aliasing into the buffer.
      axi_out_data <= w_rd_hit ? r_mem_data[rd_addr[c_PTR_W-1:0]] : '0;
      axi_wstrb    <= w_rd_hit ? r_mem_strb[rd_addr[c_PTR_W-1:0]] : '0;
    end
  end

  // Buffer storage carries no reset; PAD defines every word before a burst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem_data[r_word_idx[c_PTR_W-1:0]] <= w_commit ? w_word_data : '0;
      r_mem_strb[r_word_idx[c_PTR_W-1:0]] <= w_commit ? w_word_strb : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ofm_pack_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ofm_pack_buffer                                                       |
// | Self-checking bench: directed tile table plus randomized tiles against a |
// | byte-list reference model.  Rev 1.0                                      |
// +--------------------------------------------------------------------------+
module tb_ofm_pack_buffer;

  localparam int AW  = 32;
  localparam int DW  = 128;
  localparam int BW  = 10;
  localparam int BL  = 128;
  localparam int BPW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_last;
  logic [AW-1:0] cfg_base;
  logic          cfg_load;
  logic          start_write;
  logic [AW-1:0] base_addr;
  logic          wr_done;
  logic [BW-1:0] rd_addr;
  logic [DW-1:0] axi_out_data;
  logic [BPW-1:0] axi_wstrb;
  logic [15:0]   tile_cnt;

  ofm_pack_buffer #(
    .AXI_ADDR_W(AW), .AXI_DATA_W(DW), .BUF_ADDR_W(BW), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_last(pix_last), .cfg_base(cfg_base),
    .cfg_load(cfg_load), .start_write(start_write), .base_addr(base_addr),
    .wr_done(wr_done), .rd_addr(rd_addr), .axi_out_data(axi_out_data),
    .axi_wstrb(axi_wstrb), .tile_cnt(tile_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           n;
    bit           last;
    bit           do_cfg;
    logic [31:0]  cfg;
    logic [31:0]  exp_base;
    int           exp_lat;
    int           word;
    logic [15:0]  exp_strb;
  } vec_t;

  int            n_checks = 0;
  int            n_errors = 0;
  bit            stuck = 1'b0;
  logic [AW-1:0] m_next;
  logic [AW-1:0] m_base;
  logic [15:0]   m_cnt;
  logic [7:0]    bq      [2048];
  logic [DW-1:0] exp_data[BL];
  logic [BPW-1:0] exp_strb[BL];
  logic [DW-1:0] rb_data [BL];
  logic [BPW-1:0] rb_strb [BL];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last);
    int g = 0;
    pix_in = b; pix_last = last; pix_valid = 1'b1;
    while (!pix_ready && g < 50) begin tick; g++; end
    if (!pix_ready) begin
      chk("pix_ready_timeout", 128'(pix_ready), 128'(1));
      stuck = 1'b1;
    end
    tick;
  endtask

  task automatic cfg_pulse(input logic [31:0] v);
    cfg_load = 1'b1; cfg_base = v;
    tick;
    cfg_load = 1'b0;
    m_next = v;
  endtask

  task automatic handoff(input bit with_cfg, input logic [31:0] v);
    wr_done = 1'b1; cfg_load = with_cfg; cfg_base = v;
    tick;
    wr_done = 1'b0; cfg_load = 1'b0; pix_valid = 1'b0;
    m_cnt = m_cnt + 16'd1;
    m_next = with_cfg ? v : m_next + 32'(BL * BPW);
    chk("handoff_start_write", 128'(start_write), 128'(0));
    chk("handoff_pix_ready", 128'(pix_ready), 128'(1));
    chk("handoff_tile_cnt", 128'(tile_cnt), 128'(m_cnt));
  endtask

  // Reference: byte i of the tile lands in word i/BPW, lane i%BPW; all else zero.
  task automatic run_tile(input int n, input bit last, input bit gaps,
                          input bit seqb, input bit hold, output int lat);
    int nw = (n + BPW - 1) / BPW;
    for (int w = 0; w < BL; w++) begin exp_data[w] = '0; exp_strb[w] = '0; end
    for (int i = 0; i < n; i++) begin
      bq[i] = seqb ? 8'(i) : 8'($urandom);
      exp_data[i / BPW][8 * (i % BPW) +: 8] = bq[i];
      exp_strb[i / BPW][i % BPW] = 1'b1;
    end
    chk("fill_ready", 128'(pix_ready), 128'(1));
    for (int i = 0; i < n && !stuck; i++) begin
      if (gaps) begin
        int g = 0;
        while ($urandom_range(3) == 0 && g < 4) begin
          pix_valid = 1'b0; pix_last = 1'($urandom_range(1)); pix_in = 8'($urandom);
          tick; g++;
        end
      end
      send_byte(bq[i], last && (i == n - 1));
    end
    m_base = m_next;
    pix_valid = hold; pix_last = 1'b0; pix_in = 8'($urandom);
    chk("ready_after_tile", 128'(pix_ready), 128'(0));
    lat = 0;
    while (!start_write && lat < 300) begin tick; lat++; end
    chk("start_write_latency", 128'(lat), 128'(BL - nw));
    chk("base_addr", 128'(base_addr), 128'(m_base));
    for (int w = 0; w < BL; w++) begin
      rd_addr = BW'(w);
      if (hold) pix_in = 8'($urandom);
      tick;
      rb_data[w] = axi_out_data;
      rb_strb[w] = axi_wstrb;
      chk("read_data", axi_out_data, exp_data[w]);
      chk("read_strb", 128'(axi_wstrb), 128'(exp_strb[w]));
    end
    chk("start_write_held", 128'(start_write), 128'(1));
    chk("base_addr_held", 128'(base_addr), 128'(m_base));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int   lat;
    vecs[0] = '{2048, 1'b0, 1'b1, 32'h1000_0000, 32'h1000_0000, 0,   127, 16'hFFFF};
    vecs[1] = '{20,   1'b1, 1'b0, 32'h0,         32'h1000_0800, 126, 1,   16'h000F};
    vecs[2] = '{1,    1'b1, 1'b0, 32'h0,         32'h1000_1000, 127, 0,   16'h0001};
    vecs[3] = '{16,   1'b1, 1'b1, 32'hFFFF_F800, 32'hFFFF_F800, 127, 0,   16'hFFFF};
    vecs[4] = '{32,   1'b1, 1'b0, 32'h0,         32'h0000_0000, 126, 1,   16'hFFFF};

    rst_n = 1'b0; pix_in = '0; pix_valid = 1'b0; pix_last = 1'b0;
    cfg_base = '0; cfg_load = 1'b0; wr_done = 1'b0; rd_addr = '0;
    m_next = '0; m_cnt = '0; m_base = '0;
    repeat (3) tick;
    chk("rst_pix_ready", 128'(pix_ready), 128'(0));
    chk("rst_start_write", 128'(start_write), 128'(0));
    chk("rst_base_addr", 128'(base_addr), 128'(0));
    chk("rst_data", axi_out_data, 128'(0));
    chk("rst_strb", 128'(axi_wstrb), 128'(0));
    chk("rst_tile_cnt", 128'(tile_cnt), 128'(0));
    rst_n = 1'b1;
    chk("ready_before_edge", 128'(pix_ready), 128'(0));
    tick;
    chk("ready_after_release", 128'(pix_ready), 128'(1));

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].do_cfg) cfg_pulse(vecs[i].cfg);
      run_tile(vecs[i].n, vecs[i].last, 1'b0, 1'b1, 1'b0, lat);
      chk("vec_base", 128'(base_addr), 128'(vecs[i].exp_base));
      chk("vec_pad_cycles", 128'(lat), 128'(vecs[i].exp_lat));
      chk("vec_strb", 128'(rb_strb[vecs[i].word]), 128'(vecs[i].exp_strb));
      if (i == 0) chk("full_word0", rb_data[0], 128'h0F0E0D0C0B0A09080706050403020100);
      handoff(1'b0, 32'h0);
    end

    // wr_done outside WAIT must be ignored
    wr_done = 1'b1; tick; wr_done = 1'b0;
    chk("spurious_tile_cnt", 128'(tile_cnt), 128'(m_cnt));
    chk("spurious_start_write", 128'(start_write), 128'(0));
    chk("spurious_ready", 128'(pix_ready), 128'(1));

    // pix_valid held high through WAIT; cfg_load coincides with wr_done
    run_tile(40, 1'b1, 1'b0, 1'b0, 1'b1, lat);
    handoff(1'b1, 32'h2000_0000);
    run_tile(48, 1'b1, 1'b1, 1'b0, 1'b0, lat);
    chk("cfg_with_done_base", 128'(base_addr), 128'(32'h2000_0000));
    cfg_pulse(32'h3000_0000);
    chk("cfg_in_wait_base_stable", 128'(base_addr), 128'(32'h2000_0000));
    handoff(1'b0, 32'h0);

    for (int t = 0; t < 6 && !stuck; t++) begin
      int  n    = $urandom_range(2048, 1);
      bit  last = (t % 3) != 0;
      if (!last) n = 2048;
      if ($urandom_range(2) == 0) cfg_pulse($urandom);
      run_tile(n, last, 1'b1, 1'b0, 1'($urandom_range(1)), lat);
      handoff(1'($urandom_range(1)), $urandom);
    end

    // Reset in the middle of PAD
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), i == 4);
    pix_valid = 1'b0; pix_last = 1'b0;
    tick; tick;
    rst_n = 1'b0;
    #1;
    chk("midpad_rst_ready", 128'(pix_ready), 128'(0));
    chk("midpad_rst_start_write", 128'(start_write), 128'(0));
    chk("midpad_rst_base", 128'(base_addr), 128'(0));
    chk("midpad_rst_data", axi_out_data, 128'(0));
    chk("midpad_rst_strb", 128'(axi_wstrb), 128'(0));
    chk("midpad_rst_tile_cnt", 128'(tile_cnt), 128'(0));
    tick;
    rst_n = 1'b1;
    m_next = '0; m_cnt = '0;
    chk("midpad_ready_low", 128'(pix_ready), 128'(0));
    tick;
    run_tile(16, 1'b1, 1'b0, 1'b1, 1'b0, lat);
    chk("post_reset_word0_strb", 128'(rb_strb[0]), 128'(16'hFFFF));
    chk("post_reset_base", 128'(base_addr), 128'(0));
    handoff(1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
